// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_txrx full-duplex 8N1 UART.
package uart_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_DONE  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_DATA = 2'd1,
        RX_STOP = 2'd2,
        RX_DONE = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic [31:0] clkcount;
        logic [31:0] half;
    } baud_div_t;

    // clkcount is one bit time in clk cycles; uclk toggles every half of it.
    function automatic baud_div_t calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
        baud_div_t div;
        div.clkcount = 32'(clk_freq / baud_rate);
        div.half     = div.clkcount / 32'd2;
        return div;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud generator: free-running uclk at the bit rate plus a one-cycle tick on each uclk rise.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq  = 1000000,
    parameter int unsigned baud_rate = 9600
) (
    input  logic clk,
    input  logic rst,
    output logic uclk,
    output logic tick
);

    localparam baud_div_t   DIV   = calc_baud_div(clk_freq, baud_rate);
    localparam int unsigned HALF  = (DIV.half < 32'd1) ? 1 : int'(DIV.half);
    localparam int unsigned CNT_W = (HALF < 2) ? 1 : $clog2(HALF);

    logic [CNT_W-1:0] cnt;

    // Counting 0..HALF-1 makes each uclk phase HALF cycles, so a full period is clkcount.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            uclk <= 1'b0;
            tick <= 1'b0;
        end else if (cnt == CNT_W'(HALF - 1)) begin
            cnt  <= '0;
            uclk <= ~uclk;
            tick <= ~uclk;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART with independent TX/RX baud generators.
// Optional RX stop-bit check enabled by defining UART_RX_STOP_CHECK_EN.
module uart_txrx
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq  = 1000000,
    parameter int unsigned baud_rate = 9600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic [DATA_W-1:0] dintx,
    input  logic              newd,
    output logic              tx,
    output logic [DATA_W-1:0] doutrx,
    output logic              donetx,
    output logic              donerx
);

    logic utx_uclk, utx_tick;
    logic rtx_uclk, rtx_tick;

    uart_baud_gen #(.clk_freq(clk_freq), .baud_rate(baud_rate)) utx (
        .clk  (clk),
        .rst  (rst),
        .uclk (utx_uclk),
        .tick (utx_tick)
    );

    uart_baud_gen #(.clk_freq(clk_freq), .baud_rate(baud_rate)) rtx (
        .clk  (clk),
        .rst  (rst),
        .uclk (rtx_uclk),
        .tick (rtx_tick)
    );

    // ---------------- TX ----------------
    tx_state_t         tx_state, tx_state_nxt;
    logic [DATA_W-1:0] tx_data, tx_data_nxt;
    logic [3:0]        tx_cnt, tx_cnt_nxt;
    logic              tx_nxt, donetx_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_data  <= '0;
            tx_cnt   <= '0;
            tx       <= 1'b1;
            donetx   <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_data  <= tx_data_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx       <= tx_nxt;
            donetx   <= donetx_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_data_nxt  = tx_data;
        tx_cnt_nxt   = tx_cnt;
        tx_nxt       = tx;
        donetx_nxt   = donetx;
        if (utx_tick) begin
            case (tx_state)
                TX_IDLE: begin
                    tx_nxt = 1'b1;
                    if (newd) begin
                        tx_data_nxt  = dintx;
                        tx_nxt       = 1'b0;
                        tx_state_nxt = TX_START;
                    end
                end
                TX_START: begin
                    tx_nxt       = tx_data[0];
                    tx_cnt_nxt   = 4'd1;
                    tx_state_nxt = TX_DATA;
                end
                TX_DATA: begin
                    // tx_cnt == 8 means all data bits are out: emit the stop bit.
                    if (tx_cnt == 4'd8) begin
                        tx_nxt       = 1'b1;
                        donetx_nxt   = 1'b1;
                        tx_state_nxt = TX_DONE;
                    end else begin
                        tx_nxt     = tx_data[tx_cnt[2:0]];
                        tx_cnt_nxt = tx_cnt + 4'd1;
                    end
                end
                TX_DONE: begin
                    donetx_nxt   = 1'b0;
                    tx_state_nxt = TX_IDLE;
                end
                default: tx_state_nxt = TX_IDLE;
            endcase
        end
    end

    // ---------------- RX ----------------
    rx_state_t         rx_state, rx_state_nxt;
    logic [2:0]        rx_cnt, rx_cnt_nxt;
    logic [DATA_W-1:0] doutrx_nxt;
    logic              donerx_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            doutrx   <= '0;
            donerx   <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            doutrx   <= doutrx_nxt;
            donerx   <= donerx_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        doutrx_nxt   = doutrx;
        donerx_nxt   = donerx;
        if (rtx_tick) begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rx) begin
                        rx_cnt_nxt   = 3'd0;
                        rx_state_nxt = RX_DATA;
                    end
                end
                RX_DATA: begin
                    doutrx_nxt = {rx, doutrx[DATA_W-1:1]};
                    rx_cnt_nxt = rx_cnt + 3'd1;
                    if (rx_cnt == 3'd7) begin
`ifdef UART_RX_STOP_CHECK_EN
                        rx_state_nxt = RX_STOP;
`else
                        donerx_nxt   = 1'b1;
                        rx_state_nxt = RX_DONE;
`endif
                    end
                end
                RX_STOP: begin
                    // A low stop bit is a framing error: drop the frame silently.
                    if (rx) begin
                        donerx_nxt   = 1'b1;
                        rx_state_nxt = RX_DONE;
                    end else begin
                        rx_state_nxt = RX_IDLE;
                    end
                end
                RX_DONE: begin
                    donerx_nxt   = 1'b0;
                    rx_state_nxt = RX_IDLE;
                end
                default: rx_state_nxt = RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txrx.sv
// Directed self-checking bench for uart_txrx (honours UART_RX_STOP_CHECK_EN when defined).
`timescale 1ns/1ps
module tb_uart_txrx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] dintx;
    logic       newd;
    logic       tx;
    logic [7:0] doutrx;
    logic       donetx;
    logic       donerx;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse / high-cycle monitors for the done strobes.
    int   tx_pulses = 0, tx_hi = 0, rx_pulses = 0, rx_hi = 0;
    logic donetx_q = 1'b0, donerx_q = 1'b0;

    uart_txrx #(.clk_freq(1000000), .baud_rate(9600)) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .dintx  (dintx),
        .newd   (newd),
        .tx     (tx),
        .doutrx (doutrx),
        .donetx (donetx),
        .donerx (donerx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (donetx) tx_hi++;
        if (donetx && !donetx_q) tx_pulses++;
        if (donerx) rx_hi++;
        if (donerx && !donerx_q) rx_pulses++;
        donetx_q = donetx;
        donerx_q = donerx;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns at the first negedge with tx low; gap counts the negedges waited.
    task automatic wait_tx_start(input string tag, output int gap);
        bit found = 1'b0;
        gap = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            gap++;
            if (tx == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check({tag, "_start_timeout"}, 32'd0, 32'd1);
    endtask

    // Samples all 10 bits mid-bit; returns at the middle of the stop bit.
    task automatic sample_tx_frame(input string tag, input logic [7:0] d);
        logic [9:0] exp_bits;
        exp_bits = {1'b1, d, 1'b0};
        repeat (52) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (i != 0) repeat (104) @(negedge clk);
            check($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(exp_bits[i]));
            if (i == 8) check({tag, "_donetx_d7"}, 32'(donetx), 32'd0);
            if (i == 9) check({tag, "_donetx_stop"}, 32'(donetx), 32'd1);
        end
    endtask

    // Waits for the cycle in which the RX uclk has just risen.
    task automatic wait_rtick();
        bit   found = 1'b0;
        logic prev;
        prev = dut.rtx.uclk;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (dut.rtx.uclk && !prev) begin
                found = 1'b1;
                break;
            end
            prev = dut.rtx.uclk;
        end
        if (!found) check("rx_tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            wait_rtick();
            rx = bits[i];
        end
        wait_rtick();
        rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int gap;
        int p0, h0;

        rst = 1'b0; rx = 1'b1; newd = 1'b0; dintx = 8'h00;

        // Reset and release
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_donetx", 32'(donetx), 32'd0);
        check("rst_donerx", 32'(donerx), 32'd0);
        check("rst_doutrx", 32'(doutrx), 32'h00);
        repeat (51) @(posedge clk);
        #1;
        check("utx_uclk_early", 32'(dut.utx.uclk), 32'd0);
        check("rtx_uclk_early", 32'(dut.rtx.uclk), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("utx_uclk_rise", 32'(dut.utx.uclk), 32'd1);
        check("rtx_uclk_rise", 32'(dut.rtx.uclk), 32'd1);

        // Single TX frame 0xA5
        @(negedge clk);
        p0 = tx_pulses; h0 = tx_hi;
        dintx = 8'hA5; newd = 1'b1;
        wait_tx_start("a5", gap);
        sample_tx_frame("a5", 8'hA5);
        newd = 1'b0;
        repeat (104) @(negedge clk);
        check("a5_idle_gap", 32'(tx), 32'd1);
        check("a5_donetx_clr", 32'(donetx), 32'd0);
        repeat (156) @(negedge clk);
        check("a5_no_restart", 32'(tx), 32'd1);
        check("a5_donetx_pulses", 32'(tx_pulses - p0), 32'd1);
        check("a5_donetx_len", 32'(tx_hi - h0), 32'd104);

        // RX frame 0x3C
        p0 = rx_pulses; h0 = rx_hi;
        send_rx(8'h3C, 1'b1);
        check("rx3c_doutrx", 32'(doutrx), 32'h3C);
        check("rx3c_pulses", 32'(rx_pulses - p0), 32'd1);
        check("rx3c_len", 32'(rx_hi - h0), 32'd104);

        // Back-to-back TX 0x01 then 0xFF with newd held
        @(negedge clk);
        p0 = tx_pulses;
        dintx = 8'h01; newd = 1'b1;
        wait_tx_start("b2b0", gap);
        sample_tx_frame("b2b0", 8'h01);
        dintx = 8'hFF;
        wait_tx_start("b2b1", gap);
        check("b2b_gap", 32'(gap), 32'd156);
        newd = 1'b0;
        sample_tx_frame("b2b1", 8'hFF);
        repeat (300) @(negedge clk);
        check("b2b_pulses", 32'(tx_pulses - p0), 32'd2);

        // Reset in the middle of TX data bit 4
        p0 = tx_pulses;
        dintx = 8'hA5; newd = 1'b1;
        wait_tx_start("mid", gap);
        repeat (52 + 5 * 104) @(negedge clk);
        check("mid_bit4", 32'(tx), 32'd0);
        newd = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_donetx", 32'(donetx), 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (1500) @(negedge clk);
        check("mid_idle_tx", 32'(tx), 32'd1);
        check("mid_no_donetx", 32'(tx_pulses - p0), 32'd0);
        dintx = 8'h5A; newd = 1'b1;
        wait_tx_start("post", gap);
        sample_tx_frame("post", 8'h5A);
        newd = 1'b0;
        repeat (300) @(negedge clk);
        check("post_pulses", 32'(tx_pulses - p0), 32'd1);

        // RX stop-bit handling
        p0 = rx_pulses;
`ifdef UART_RX_STOP_CHECK_EN
        send_rx(8'h55, 1'b0);
        check("rx55_bad_doutrx", 32'(doutrx), 32'h55);
        check("rx55_bad_pulses", 32'(rx_pulses - p0), 32'd0);
        send_rx(8'h55, 1'b1);
        check("rx55_ok_doutrx", 32'(doutrx), 32'h55);
        check("rx55_ok_pulses", 32'(rx_pulses - p0), 32'd1);
`else
        send_rx(8'h55, 1'b1);
        check("rx55_doutrx", 32'(doutrx), 32'h55);
        check("rx55_pulses", 32'(rx_pulses - p0), 32'd1);
        send_rx(8'h80, 1'b1);
        check("rx80_doutrx", 32'(doutrx), 32'h80);
        check("rx80_pulses", 32'(rx_pulses - p0), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
